// File: rtl/pacman_pkg.sv
// Shared maze constants, pellet/state types and the level-start pellet layout ROM.
package pacman_pkg;

    localparam int MAP_W  = 28;
    localparam int MAP_H  = 31;
    localparam int N      = MAP_W * MAP_H;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        PEL_NONE  = 2'd0,
        PEL_SMALL = 2'd1,
        PEL_LARGE = 2'd2
    } pellet_t;

    typedef enum logic [1:0] {
        ST_REFILL,
        ST_IDLE,
        ST_EAT_RD,
        ST_EAT_WR
    } ctrl_state_t;

    typedef logic [N-1:0][1:0] rom_t;

    // Power pellets in the four corners; columns 13/14 are the empty centre corridor.
    function automatic pellet_t layout(input int x, input int y);
        if ((x == 0 || x == MAP_W - 1) && (y == 2 || y == 23)) return PEL_LARGE;
        if (x == 13 || x == 14) return PEL_NONE;
        if ((y % 3) == 0 || (x % 3) == 1) return PEL_SMALL;
        return PEL_NONE;
    endfunction

    function automatic rom_t build_rom();
        rom_t r;
        r = '0;
        for (int y = 0; y < MAP_H; y++) begin
            for (int x = 0; x < MAP_W; x++) begin
                r[y * MAP_W + x] = layout(x, y);
            end
        end
        return r;
    endfunction

    localparam rom_t PELLET_ROM = build_rom();

    function automatic int count_rom();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (PELLET_ROM[i] != 2'd0) c++;
        end
        return c;
    endfunction

    localparam int PELLET_TOTAL = count_rom();

    function automatic logic tile_in_range(input logic [4:0] x, input logic [4:0] y);
        return (x < 5'(MAP_W)) && (y < 5'(MAP_H));
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] x, input logic [4:0] y);
        return ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pellet_ram.sv
// N x 2-bit dual-port map RAM: port A read-only, port B read/write, registered reads.
module pellet_ram
    import pacman_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [1:0]        a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic [1:0]        b_wdata,
    output logic [1:0]        b_rdata
);

    logic [1:0] mem_q [N];
    logic [1:0] a_rdata_q;
    logic [1:0] b_rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; contents come from the refill sweep.
    // Both ports share one process so a same-edge write leaves the old word on either read port.
    always_ff @(posedge clk) begin
        a_rdata_q <= mem_q[a_addr];
        b_rdata_q <= mem_q[b_addr];
        if (b_we) begin
            mem_q[b_addr] <= b_wdata;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/pellet_ctrl.sv
// Live pellet map owner: ROM refill sweep, renderer read port and eat read-modify-write.
module pellet_ctrl
    import pacman_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       level_start,
    input  logic [4:0] gfx_x,
    input  logic [4:0] gfx_y,
    output logic [1:0] gfx_pellet,
    input  logic       eat_req,
    input  logic [4:0] eat_x,
    input  logic [4:0] eat_y,
    output logic       eat_ack,
    output logic       eat_hit,
    output logic [1:0] eat_type,
    output logic [9:0] pellets_left,
    output logic       busy,
    output logic       level_clear
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [9:0]        pellets_q, pellets_d;
    logic [ADDR_W-1:0] eat_addr_q, eat_addr_d;
    logic              pending_q, pending_d;
    logic              oor_ack_q, oor_ack_d;
    logic              clear_q, clear_d;
    logic              gfx_valid_q, gfx_valid_d;

    logic [ADDR_W-1:0] gfx_addr;
    logic [1:0]        gfx_rdata;
    logic [ADDR_W-1:0] b_addr;
    logic              b_we;
    logic [1:0]        b_wdata;
    logic [1:0]        b_rdata;
    logic [1:0]        rom_val;
    logic              wr_ack, wr_hit;
    logic [1:0]        wr_type;
    logic              gfx_in;

    assign busy   = (state_q == ST_REFILL);
    assign gfx_in = tile_in_range(gfx_x, gfx_y);
    // Out-of-range coordinates are steered to tile 0 so the RAM index always stays inside N.
    assign gfx_addr    = gfx_in ? tile_addr(gfx_x, gfx_y) : '0;
    assign gfx_valid_d = gfx_in && !busy;
    assign rom_val     = PELLET_ROM[addr_q];

    pellet_ram u_ram (
        .clk     (clk),
        .a_addr  (gfx_addr),
        .a_rdata (gfx_rdata),
        .b_addr  (b_addr),
        .b_we    (b_we && !rst),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        pellets_d  = pellets_q;
        eat_addr_d = eat_addr_q;
        pending_d  = pending_q;
        oor_ack_d  = 1'b0;
        clear_d    = 1'b0;
        b_addr     = addr_q;
        b_we       = 1'b0;
        b_wdata    = 2'd0;
        wr_ack     = 1'b0;
        wr_hit     = 1'b0;
        wr_type    = 2'd0;

        case (state_q)
            ST_REFILL: begin
                b_we    = 1'b1;
                b_wdata = rom_val;
                count_d = count_q + ADDR_W'(rom_val != 2'd0);
                addr_d  = addr_q + ADDR_W'(1);
                if (level_start) begin
                    addr_d  = '0;
                    count_d = '0;
                end else if (addr_q == LAST_ADDR) begin
                    pellets_d = count_d;
                    addr_d    = '0;
                    state_d   = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (level_start || pending_q) begin
                    state_d   = ST_REFILL;
                    addr_d    = '0;
                    count_d   = '0;
                    pellets_d = '0;
                    pending_d = 1'b0;
                end else if (eat_req) begin
                    if (tile_in_range(eat_x, eat_y)) begin
                        eat_addr_d = tile_addr(eat_x, eat_y);
                        state_d    = ST_EAT_RD;
                    end else begin
                        oor_ack_d = 1'b1;
                    end
                end
            end

            ST_EAT_RD: begin
                b_addr  = eat_addr_q;
                state_d = ST_EAT_WR;
                if (level_start) pending_d = 1'b1;
            end

            ST_EAT_WR: begin
                b_addr = eat_addr_q;
                wr_ack = 1'b1;
                if (b_rdata != 2'd0) begin
                    b_we      = 1'b1;
                    wr_hit    = 1'b1;
                    wr_type   = b_rdata;
                    pellets_d = pellets_q - 10'd1;
                    clear_d   = (pellets_q == 10'd1);
                end
                if (level_start) pending_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_REFILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REFILL;
            addr_q      <= '0;
            count_q     <= '0;
            pellets_q   <= '0;
            eat_addr_q  <= '0;
            pending_q   <= 1'b0;
            oor_ack_q   <= 1'b0;
            clear_q     <= 1'b0;
            gfx_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            pellets_q   <= pellets_d;
            eat_addr_q  <= eat_addr_d;
            pending_q   <= pending_d;
            oor_ack_q   <= oor_ack_d;
            clear_q     <= clear_d;
            gfx_valid_q <= gfx_valid_d;
        end
    end

    // Reset also masks the in-flight eat response so an aborted request never acknowledges.
    assign eat_ack      = !rst && (wr_ack || oor_ack_q);
    assign eat_hit      = !rst && wr_hit;
    assign eat_type     = rst ? 2'd0 : wr_type;
    assign pellets_left = pellets_q;
    assign level_clear  = clear_q;
    assign gfx_pellet   = gfx_valid_q ? gfx_rdata : 2'd0;

endmodule

// File: tb/tb_pellet_ctrl.sv
// Directed self-checking bench for pellet_ctrl: refill, renderer port, eats, level_start, reset.
module tb_pellet_ctrl;

    localparam int TOTAL = 450;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       level_start = 1'b0;
    logic [4:0] gfx_x = '0;
    logic [4:0] gfx_y = '0;
    logic [1:0] gfx_pellet;
    logic       eat_req = 1'b0;
    logic [4:0] eat_x = '0;
    logic [4:0] eat_y = '0;
    logic       eat_ack;
    logic       eat_hit;
    logic [1:0] eat_type;
    logic [9:0] pellets_left;
    logic       busy;
    logic       level_clear;

    int tests_run = 0;
    int tests_failed = 0;
    logic [1:0] shadow [868];
    int exp_left;

    always #5 clk = ~clk;

    pellet_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .level_start  (level_start),
        .gfx_x        (gfx_x),
        .gfx_y        (gfx_y),
        .gfx_pellet   (gfx_pellet),
        .eat_req      (eat_req),
        .eat_x        (eat_x),
        .eat_y        (eat_y),
        .eat_ack      (eat_ack),
        .eat_hit      (eat_hit),
        .eat_type     (eat_type),
        .pellets_left (pellets_left),
        .busy         (busy),
        .level_clear  (level_clear)
    );

    // Reference layout: corner power pellets, empty columns 13/14, small on every 3rd row / column 1 mod 3.
    function automatic logic [1:0] model(input int x, input int y);
        if ((x == 0 || x == 27) && (y == 2 || y == 23)) return 2'd2;
        if (x == 13 || x == 14) return 2'd0;
        if ((y % 3) == 0 || (x % 3) == 1) return 2'd1;
        return 2'd0;
    endfunction

    task automatic load_shadow();
        for (int y = 0; y < 31; y++)
            for (int x = 0; x < 28; x++)
                shadow[y * 28 + x] = model(x, y);
        exp_left = TOTAL;
    endtask

    task automatic wait_refill(output int cyc, output bit saw_clear, output bit saw_left,
                               output bit saw_ack, output bit saw_gfx);
        cyc = 0; saw_clear = 0; saw_left = 0; saw_ack = 0; saw_gfx = 0;
        while (busy === 1'b1 && cyc < 2000) begin
            cyc++;
            if (level_clear !== 1'b0) saw_clear = 1;
            if (pellets_left !== 10'd0) saw_left = 1;
            if (eat_ack !== 1'b0) saw_ack = 1;
            if (gfx_pellet !== 2'd0) saw_gfx = 1;
            @(negedge clk);
        end
    endtask

    task automatic do_eat(input int x, input int y, output int lat, output logic hit,
                          output logic [1:0] typ);
        eat_x = 5'(x); eat_y = 5'(y); eat_req = 1'b1;
        lat = -1; hit = 1'bx; typ = 2'bxx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (eat_ack === 1'b1) begin
                lat = i; hit = eat_hit; typ = eat_type;
                break;
            end
        end
        eat_req = 1'b0;
    endtask

    task automatic test_reset();
        int cyc; bit sc, sl, sa, sg;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        tests_run++;
        if ({busy, eat_ack, eat_hit, eat_type, pellets_left, level_clear, gfx_pellet} !== {1'b1, 17'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b ack=%b hit=%b type=%0d left=%0d clr=%b gfx=%0d want busy=1 others 0",
                     busy, eat_ack, eat_hit, eat_type, pellets_left, level_clear, gfx_pellet);
        end
        wait_refill(cyc, sc, sl, sa, sg);
        tests_run++;
        if (cyc != 868) begin tests_failed++; $display("FAIL reset_busy_cycles: got %0d want 868", cyc); end
        tests_run++;
        if (sc || sl || sa) begin
            tests_failed++;
            $display("FAIL reset_refill_quiet: clear=%0b left_nonzero=%0b ack=%0b want all 0", sc, sl, sa);
        end
        tests_run++;
        if (pellets_left !== 10'(TOTAL)) begin
            tests_failed++; $display("FAIL reset_pellets_left: got %0d want %0d", pellets_left, TOTAL);
        end
        load_shadow();
    endtask

    task automatic test_gfx_sweep();
        int bad = 0;
        for (int y = 0; y < 31; y++) begin
            for (int x = 0; x < 28; x++) begin
                gfx_x = 5'(x); gfx_y = 5'(y);
                @(negedge clk);
                tests_run++;
                if (gfx_pellet !== shadow[y * 28 + x]) begin
                    tests_failed++; bad++;
                    if (bad <= 10)
                        $display("FAIL gfx_tile(%0d,%0d): got %0d want %0d", x, y, gfx_pellet, shadow[y * 28 + x]);
                end
            end
        end
        gfx_x = 5'd28; gfx_y = 5'd0; @(negedge clk);
        tests_run++;
        if (gfx_pellet !== 2'd0) begin tests_failed++; $display("FAIL gfx_x28: got %0d want 0", gfx_pellet); end
        gfx_x = 5'd1; gfx_y = 5'd31; @(negedge clk);
        tests_run++;
        if (gfx_pellet !== 2'd0) begin tests_failed++; $display("FAIL gfx_y31: got %0d want 0", gfx_pellet); end
    endtask

    task automatic test_eat_basic();
        int lat; logic hit; logic [1:0] typ;
        gfx_x = 5'd1; gfx_y = 5'd0;
        do_eat(1, 0, lat, hit, typ);
        tests_run++;
        if (lat != 2 || hit !== 1'b1 || typ !== 2'd1) begin
            tests_failed++; $display("FAIL eat_1_0: lat=%0d hit=%b type=%0d want lat=2 hit=1 type=1", lat, hit, typ);
        end
        @(negedge clk);
        tests_run++;
        if (pellets_left !== 10'd449 || gfx_pellet !== 2'd1 || level_clear !== 1'b0) begin
            tests_failed++;
            $display("FAIL eat_1_0_after: left=%0d gfx=%0d clr=%b want 449 1 0", pellets_left, gfx_pellet, level_clear);
        end
        @(negedge clk);
        tests_run++;
        if (gfx_pellet !== 2'd0) begin tests_failed++; $display("FAIL gfx_after_eat: got %0d want 0", gfx_pellet); end
        shadow[1] = 2'd0; exp_left = 449;

        do_eat(1, 0, lat, hit, typ); @(negedge clk);
        tests_run++;
        if (lat != 2 || hit !== 1'b0 || typ !== 2'd0 || pellets_left !== 10'd449) begin
            tests_failed++;
            $display("FAIL eat_repeat: lat=%0d hit=%b type=%0d left=%0d want 2 0 0 449", lat, hit, typ, pellets_left);
        end

        do_eat(0, 2, lat, hit, typ); @(negedge clk);
        tests_run++;
        if (lat != 2 || hit !== 1'b1 || typ !== 2'd2 || pellets_left !== 10'd448) begin
            tests_failed++;
            $display("FAIL eat_large: lat=%0d hit=%b type=%0d left=%0d want 2 1 2 448", lat, hit, typ, pellets_left);
        end
        shadow[56] = 2'd0; exp_left = 448;

        do_eat(13, 0, lat, hit, typ); @(negedge clk);
        tests_run++;
        if (lat != 2 || hit !== 1'b0 || typ !== 2'd0 || pellets_left !== 10'd448) begin
            tests_failed++;
            $display("FAIL eat_empty: lat=%0d hit=%b type=%0d left=%0d want 2 0 0 448", lat, hit, typ, pellets_left);
        end

        do_eat(30, 5, lat, hit, typ); @(negedge clk);
        tests_run++;
        if (lat != 1 || hit !== 1'b0 || typ !== 2'd0 || pellets_left !== 10'd448) begin
            tests_failed++;
            $display("FAIL eat_out_of_range: lat=%0d hit=%b type=%0d left=%0d want 1 0 0 448", lat, hit, typ, pellets_left);
        end
    endtask

    task automatic test_level_start();
        int cyc, n; bit sc, sl, sa, sg; logic got;
        gfx_x = 5'd1; gfx_y = 5'd0;
        eat_x = 5'd4; eat_y = 5'd0; eat_req = 1'b1;
        @(negedge clk);
        level_start = 1'b1;
        @(negedge clk);
        level_start = 1'b0;
        tests_run++;
        if (eat_ack !== 1'b1 || eat_hit !== 1'b1 || eat_type !== 2'd1) begin
            tests_failed++;
            $display("FAIL ls_eat_ack: ack=%b hit=%b type=%0d want 1 1 1", eat_ack, eat_hit, eat_type);
        end
        eat_req = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL ls_refill_start: busy=%b want 1", busy); end
        gfx_x = 5'd0; gfx_y = 5'd23;
        eat_x = 5'd7; eat_y = 5'd0; eat_req = 1'b1;
        wait_refill(cyc, sc, sl, sa, sg);
        tests_run++;
        if (cyc != 868 || sc || sl || sa || sg) begin
            tests_failed++;
            $display("FAIL ls_refill: cycles=%0d clear=%0b left_nz=%0b ack=%0b gfx_nz=%0b want 868 0 0 0 0",
                     cyc, sc, sl, sa, sg);
        end
        tests_run++;
        if (pellets_left !== 10'(TOTAL)) begin
            tests_failed++; $display("FAIL ls_restored: left=%0d want %0d", pellets_left, TOTAL);
        end
        load_shadow();
        @(negedge clk);
        tests_run++;
        if (gfx_pellet !== 2'd2) begin tests_failed++; $display("FAIL ls_gfx_after: got %0d want 2", gfx_pellet); end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (eat_ack === 1'b1) begin
                got = 1'b1;
                tests_run++;
                if (eat_hit !== 1'b1 || eat_type !== 2'd1) begin
                    tests_failed++; $display("FAIL ls_held_eat: hit=%b type=%0d want 1 1", eat_hit, eat_type);
                end
                eat_req = 1'b0;
            end
            @(negedge clk);
        end
        eat_req = 1'b0;
        tests_run++;
        if (!got || pellets_left !== 10'd449) begin
            tests_failed++; $display("FAIL ls_held_eat_done: acked=%b left=%0d want 1 449", got, pellets_left);
        end
        shadow[7] = 2'd0; exp_left = 449;
    endtask

    task automatic test_eat_all();
        int lat, bad; logic hit; logic [1:0] typ;
        bad = 0;
        for (int a = 0; a < 868; a++) begin
            if (shadow[a] != 2'd0) begin
                do_eat(a % 28, a / 28, lat, hit, typ);
                exp_left--;
                @(negedge clk);
                tests_run++;
                if (lat != 2 || hit !== 1'b1 || typ !== shadow[a] || pellets_left !== 10'(exp_left) ||
                    level_clear !== (exp_left == 0)) begin
                    tests_failed++; bad++;
                    if (bad <= 10)
                        $display("FAIL eat_all_tile%0d: lat=%0d hit=%b type=%0d left=%0d clr=%b want 2 1 %0d %0d %0b",
                                 a, lat, hit, typ, pellets_left, level_clear, shadow[a], exp_left, exp_left == 0);
                end
                shadow[a] = 2'd0;
            end
        end
        @(negedge clk);
        tests_run++;
        if (level_clear !== 1'b0 || pellets_left !== 10'd0) begin
            tests_failed++; $display("FAIL clear_single_pulse: clr=%b left=%0d want 0 0", level_clear, pellets_left);
        end
        do_eat(4, 0, lat, hit, typ); @(negedge clk);
        tests_run++;
        if (hit !== 1'b0 || level_clear !== 1'b0 || pellets_left !== 10'd0) begin
            tests_failed++;
            $display("FAIL eat_after_clear: hit=%b clr=%b left=%0d want 0 0 0", hit, level_clear, pellets_left);
        end
        do_eat(0, 23, lat, hit, typ); @(negedge clk);
        tests_run++;
        if (hit !== 1'b0 || level_clear !== 1'b0 || pellets_left !== 10'd0) begin
            tests_failed++;
            $display("FAIL no_underflow: hit=%b clr=%b left=%0d want 0 0 0", hit, level_clear, pellets_left);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit sc, sl, sa, sg;
        level_start = 1'b1; @(negedge clk); level_start = 1'b0;
        repeat (400) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || pellets_left !== 10'd0 || eat_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_refill_outputs: busy=%b left=%0d ack=%b want 1 0 0", busy, pellets_left, eat_ack);
        end
        wait_refill(cyc, sc, sl, sa, sg);
        tests_run++;
        if (cyc != 868 || sc || sl || pellets_left !== 10'(TOTAL)) begin
            tests_failed++;
            $display("FAIL rst_refill_restart: cycles=%0d clear=%0b left_nz=%0b left=%0d want 868 0 0 %0d",
                     cyc, sc, sl, pellets_left, TOTAL);
        end
        gfx_x = 5'd4; gfx_y = 5'd0;
        eat_x = 5'd4; eat_y = 5'd0; eat_req = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1; #1;
        tests_run++;
        if (eat_ack !== 1'b0 || eat_hit !== 1'b0 || eat_type !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_eat_wr_outputs: ack=%b hit=%b type=%0d want 0 0 0", eat_ack, eat_hit, eat_type);
        end
        eat_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        wait_refill(cyc, sc, sl, sa, sg);
        tests_run++;
        if (cyc != 868 || sa || pellets_left !== 10'(TOTAL)) begin
            tests_failed++;
            $display("FAIL rst_eat_wr_refill: cycles=%0d ack=%0b left=%0d want 868 0 %0d", cyc, sa, pellets_left, TOTAL);
        end
        @(negedge clk);
        tests_run++;
        if (gfx_pellet !== 2'd1) begin tests_failed++; $display("FAIL rst_eat_wr_tile: got %0d want 1", gfx_pellet); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_gfx_sweep();
        test_eat_basic();
        test_level_start();
        test_eat_all();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
